// File: rtl/mat_store.sv
// mat_store: two-slot matrix store feeding the matrix multiplier.
// Row-major element streams are written into one of two slots through a
// small load FSM; a 1-cycle-latency random-access read port serves the
// multiplier. Per-slot valid flags and committed dimensions are exported.
// Optional build macro MAT_STORE_BOUNDS_CHECK_EN: reads outside the
// committed dimensions (or of an invalid slot) return 0 with rd_oob set.
module mat_store #(
    parameter int DIM_WIDTH  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_begin,
    input  logic                  wr_slot,
    input  logic [DIM_WIDTH-1:0]  wr_rows,
    input  logic [DIM_WIDTH-1:0]  wr_cols,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_elem,
    input  logic                  wr_abort,
    output logic                  wr_ready,
    output logic                  wr_done,
    output logic                  wr_error,
    input  logic                  rd_en,
    input  logic                  rd_slot_idx,
    input  logic [DIM_WIDTH-1:0]  rd_row_idx,
    input  logic [DIM_WIDTH-1:0]  rd_col_idx,
    output logic [DATA_WIDTH-1:0] rd_elem,
    output logic                  rd_elem_valid,
    output logic                  rd_oob,
    output logic                  slot0_valid,
    output logic                  slot1_valid,
    output logic [DIM_WIDTH-1:0]  slot0_rows,
    output logic [DIM_WIDTH-1:0]  slot0_cols,
    output logic [DIM_WIDTH-1:0]  slot1_rows,
    output logic [DIM_WIDTH-1:0]  slot1_cols
);

    localparam int DEPTH  = MAX_DIM * MAX_DIM;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_MAX = DIM_WIDTH'(MAX_DIM);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_COMMIT
    } wstate_t;

    wstate_t state;
    wstate_t state_nx;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic                 cur_slot;
    logic [DIM_WIDTH-1:0] cur_rows;
    logic [DIM_WIDTH-1:0] cur_cols;
    logic [DIM_WIDTH-1:0] row_cnt;
    logic [DIM_WIDTH-1:0] col_cnt;

    logic dims_ok;
    logic begin_ok;
    logic begin_bad;
    logic accept;
    logic last_col;
    logic last_elem;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Flat address row*MAX_DIM+col; indices beyond the array fold to 0
    function automatic logic [ADDR_W-1:0] addr_of(input logic [DIM_WIDTH-1:0] r,
                                                   input logic [DIM_WIDTH-1:0] c);
        int a;
        a = int'(r) * MAX_DIM + int'(c);
        if (a >= DEPTH) begin
            a = 0;
        end
        return ADDR_W'(a);
    endfunction

    assign dims_ok   = (wr_rows >= DIM_ONE) && (wr_rows <= DIM_MAX) &&
                       (wr_cols >= DIM_ONE) && (wr_cols <= DIM_MAX);
    assign begin_ok  = (state == W_IDLE) && wr_begin && dims_ok;
    assign begin_bad = (state == W_IDLE) && wr_begin && !dims_ok;
    assign accept    = (state == W_FILL) && wr_valid && !wr_abort;
    assign last_col  = (col_cnt == cur_cols - DIM_ONE);
    assign last_elem = last_col && (row_cnt == cur_rows - DIM_ONE);
    assign wr_addr   = addr_of(row_cnt, col_cnt);
    assign rd_addr   = addr_of(rd_row_idx, rd_col_idx);

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= W_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Write FSM next-state and handshake outputs
    always_comb begin
        state_nx = state;
        wr_ready = 1'b0;
        wr_done  = 1'b0;
        case (state)
            W_IDLE: begin
                if (begin_ok) begin
                    state_nx = W_FILL;
                end
            end
            W_FILL: begin
                wr_ready = 1'b1;
                if (wr_abort) begin
                    state_nx = W_IDLE;
                end else if (accept && last_elem) begin
                    state_nx = W_COMMIT;
                end
            end
            W_COMMIT: begin
                wr_done  = 1'b1;
                state_nx = W_IDLE;
            end
            default: begin
                state_nx = W_IDLE;
            end
        endcase
    end

    // Load context: latched target/dimensions and row-major position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_slot <= 1'b0;
            cur_rows <= '0;
            cur_cols <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (begin_ok) begin
            cur_slot <= wr_slot;
            cur_rows <= wr_rows;
            cur_cols <= wr_cols;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + DIM_ONE;
            end else begin
                col_cnt <= col_cnt + DIM_ONE;
            end
        end
    end

    // Illegal-dimension pulse, one cycle after the offending wr_begin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_error <= 1'b0;
        end else begin
            wr_error <= begin_bad;
        end
    end

    // Slot flags: cleared when a load starts, set with dimensions on the final accept
    // so they become visible together with wr_done in the commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_valid <= 1'b0;
            slot1_valid <= 1'b0;
            slot0_rows  <= '0;
            slot0_cols  <= '0;
            slot1_rows  <= '0;
            slot1_cols  <= '0;
        end else if (begin_ok) begin
            if (wr_slot) begin
                slot1_valid <= 1'b0;
            end else begin
                slot0_valid <= 1'b0;
            end
        end else if (accept && last_elem) begin
            if (cur_slot) begin
                slot1_valid <= 1'b1;
                slot1_rows  <= cur_rows;
                slot1_cols  <= cur_cols;
            end else begin
                slot0_valid <= 1'b1;
                slot0_rows  <= cur_rows;
                slot0_cols  <= cur_cols;
            end
        end
    end

    // Element storage, not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[cur_slot][wr_addr] <= wr_elem;
        end
    end

`ifdef MAT_STORE_BOUNDS_CHECK_EN
    logic                 sel_valid;
    logic [DIM_WIDTH-1:0] sel_rows;
    logic [DIM_WIDTH-1:0] sel_cols;
    logic                 rd_bad;

    assign sel_valid = rd_slot_idx ? slot1_valid : slot0_valid;
    assign sel_rows  = rd_slot_idx ? slot1_rows  : slot0_rows;
    assign sel_cols  = rd_slot_idx ? slot1_cols  : slot0_cols;
    assign rd_bad    = !sel_valid || (rd_row_idx >= sel_rows) || (rd_col_idx >= sel_cols);

    // Read port with range check: out-of-range reads return 0 and flag rd_oob
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_elem       <= '0;
            rd_elem_valid <= 1'b0;
            rd_oob        <= 1'b0;
        end else begin
            rd_elem_valid <= rd_en;
            rd_oob        <= rd_en && rd_bad;
            if (rd_en) begin
                rd_elem <= rd_bad ? '0 : mem[rd_slot_idx][rd_addr];
            end
        end
    end
`else
    assign rd_oob = 1'b0;

    // Read port: registered data, held while no read is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_elem       <= '0;
            rd_elem_valid <= 1'b0;
        end else begin
            rd_elem_valid <= rd_en;
            if (rd_en) begin
                rd_elem <= mem[rd_slot_idx][rd_addr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mat_store.sv
// Self-checking bench for mat_store: read results go through a scoreboard
// queue filled at issue time from a row/column array model of both slots.
module tb_mat_store;

    localparam int DW = 3;
    localparam int DATW = 8;
    localparam int MD = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_begin = 1'b0;
    logic            wr_slot = 1'b0;
    logic [DW-1:0]   wr_rows = '0;
    logic [DW-1:0]   wr_cols = '0;
    logic            wr_valid = 1'b0;
    logic [DATW-1:0] wr_elem = '0;
    logic            wr_abort = 1'b0;
    logic            wr_ready, wr_done, wr_error;
    logic            rd_en = 1'b0;
    logic            rd_slot_idx = 1'b0;
    logic [DW-1:0]   rd_row_idx = '0;
    logic [DW-1:0]   rd_col_idx = '0;
    logic [DATW-1:0] rd_elem;
    logic            rd_elem_valid, rd_oob;
    logic            slot0_valid, slot1_valid;
    logic [DW-1:0]   slot0_rows, slot0_cols, slot1_rows, slot1_cols;

    mat_store #(.DIM_WIDTH(DW), .DATA_WIDTH(DATW), .MAX_DIM(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_begin(wr_begin), .wr_slot(wr_slot), .wr_rows(wr_rows), .wr_cols(wr_cols),
        .wr_valid(wr_valid), .wr_elem(wr_elem), .wr_abort(wr_abort),
        .wr_ready(wr_ready), .wr_done(wr_done), .wr_error(wr_error),
        .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
        .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid), .rd_oob(rd_oob),
        .slot0_valid(slot0_valid), .slot1_valid(slot1_valid),
        .slot0_rows(slot0_rows), .slot0_cols(slot0_cols),
        .slot1_rows(slot1_rows), .slot1_cols(slot1_cols)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: matrix contents by [slot][row][col], flags and dims
    logic [DATW-1:0] m_mem [2][MD][MD];
    bit              m_valid [2];
    int              m_rows [2];
    int              m_cols [2];

    typedef struct {
        logic [DATW-1:0] data;
        logic            oob;
        int              cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic slot_valid(input int s);
        return s[0] ? slot1_valid : slot0_valid;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a read result is presented
    logic [DATW-1:0] last_elem = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_elem = '0;
        end else if (rd_elem_valid) begin
            if (q.size() == 0) begin
                chk("rd_unexpected_valid", 32'(rd_elem_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("rd_latency", cyc, e.cyc + 1);
                chk("rd_elem", 32'(rd_elem), 32'(e.data));
                chk("rd_oob", 32'(rd_oob), 32'(e.oob));
            end
            last_elem = rd_elem;
        end else begin
            chk("rd_hold", 32'(rd_elem), 32'(last_elem));
            if (q.size() > 0 && q[0].cyc + 1 <= cyc) begin
                chk("rd_missing", 32'(rd_elem_valid), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic read(input int s, input int r, input int c);
        exp_t e;
        rd_en = 1'b1;
        rd_slot_idx = s[0];
        rd_row_idx = r[DW-1:0];
        rd_col_idx = c[DW-1:0];
`ifdef MAT_STORE_BOUNDS_CHECK_EN
        e.oob = !m_valid[s] || r >= m_rows[s] || c >= m_cols[s];
        if (e.oob) e.data = '0;
        else e.data = m_mem[s][r][c];
`else
        e.oob = 1'b0;
        e.data = m_mem[s][r][c];
`endif
        e.cyc = cyc;
        q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic read_all(input int s);
        for (int r = 0; r < m_rows[s]; r++)
            for (int c = 0; c < m_cols[s]; c++)
                read(s, r, c);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Load a slot; abort_at >= 0 aborts (with a same-cycle element) at that index
    task automatic load(input int s, input int rows, input int cols,
                        input int gap_pct, input int abort_at, input bit seq);
        int n;
        logic [DATW-1:0] v;
        n = rows * cols;
        wr_slot = s[0];
        wr_rows = rows[DW-1:0];
        wr_cols = cols[DW-1:0];
        wr_begin = 1'b1;
        tick();
        wr_begin = 1'b0;
        m_valid[s] = 1'b0;
        chk("begin_ready", 32'(wr_ready), 32'd1);
        chk("begin_clears_valid", 32'(slot_valid(s)), 32'd0);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
                wr_valid = 1'b0;
                tick();
            end
            v = seq ? 8'(k + 1) : 8'($urandom);
            if (k == abort_at) begin
                wr_abort = 1'b1;
                wr_valid = 1'b1;
                wr_elem = v;
                tick();
                wr_abort = 1'b0;
                wr_valid = 1'b0;
                chk("abort_ready_low", 32'(wr_ready), 32'd0);
                chk("abort_no_done", 32'(wr_done), 32'd0);
                chk("abort_slot_invalid", 32'(slot_valid(s)), 32'd0);
                return;
            end
            wr_valid = 1'b1;
            wr_elem = v;
            m_mem[s][k / cols][k % cols] = v;
            tick();
        end
        wr_valid = 1'b0;
        chk("done_pulse", 32'(wr_done), 32'd1);
        chk("commit_valid", 32'(slot_valid(s)), 32'd1);
        chk("commit_rows", 32'(s[0] ? slot1_rows : slot0_rows), rows);
        chk("commit_cols", 32'(s[0] ? slot1_cols : slot0_cols), cols);
        m_valid[s] = 1'b1;
        m_rows[s] = rows;
        m_cols[s] = cols;
        tick();
        chk("done_one_cycle", 32'(wr_done), 32'd0);
        chk("ready_low_after", 32'(wr_ready), 32'd0);
    endtask

    task automatic bad_begin(input int s, input int rows, input int cols);
        wr_slot = s[0];
        wr_rows = rows[DW-1:0];
        wr_cols = cols[DW-1:0];
        wr_begin = 1'b1;
        tick();
        wr_begin = 1'b0;
        chk("err_pulse", 32'(wr_error), 32'd1);
        chk("err_no_ready", 32'(wr_ready), 32'd0);
        chk("err_valid_kept", 32'(slot_valid(s)), 32'(m_valid[s]));
        tick();
        chk("err_one_cycle", 32'(wr_error), 32'd0);
        chk("err_still_idle", 32'(wr_ready), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
        chk({tag, "_wr_done"}, 32'(wr_done), 0);
        chk({tag, "_wr_error"}, 32'(wr_error), 0);
        chk({tag, "_rd_valid"}, 32'(rd_elem_valid), 0);
        chk({tag, "_rd_elem"}, 32'(rd_elem), 0);
        chk({tag, "_rd_oob"}, 32'(rd_oob), 0);
        chk({tag, "_slot_valid"}, {30'd0, slot1_valid, slot0_valid}, 0);
        chk({tag, "_dims"}, {20'd0, slot0_rows, slot0_cols, slot1_rows, slot1_cols}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, r, c;
        m_valid[0] = 0; m_valid[1] = 0;
        m_rows[0] = 0; m_rows[1] = 0; m_cols[0] = 0; m_cols[1] = 0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // slot0 as 2x3 with 1..6, continuous
        load(0, 2, 3, 0, -1, 1'b1);
        read(0, 1, 2);
        drain();
`ifdef MAT_STORE_BOUNDS_CHECK_EN
        read(0, 2, 1);
        read(0, 0, 3);
        read(1, 0, 0);
        drain();
`endif

        // slot1 as 3x2 with gaps, then back-to-back reads; slot0 untouched
        load(1, 3, 2, 50, -1, 1'b0);
        read_all(1);
        read_all(0);
        drain();

        // illegal dimensions
        bad_begin(0, 0, 3);
        bad_begin(0, 6, 3);
        bad_begin(1, 2, 0);
        bad_begin(1, 3, 7);
        chk("err_slot0_dims", 32'(slot0_rows), 32'd2);

        // abort a reload of slot0, then immediately reload it
        load(0, 2, 2, 0, 2, 1'b0);
        load(0, 2, 2, 0, -1, 1'b0);
        read_all(0);
        read_all(1);
        drain();

        // reset during a fill
        wr_slot = 1'b1; wr_rows = 3'd2; wr_cols = 3'd2; wr_begin = 1'b1;
        tick();
        wr_begin = 1'b0;
        wr_valid = 1'b1; wr_elem = 8'hA5;
        tick();
        wr_valid = 1'b0;
        chk("prereset_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid[0] = 0; m_valid[1] = 0;
        m_rows[0] = 0; m_rows[1] = 0; m_cols[0] = 0; m_cols[1] = 0;
        tick();
        chk("post_reset_ready", 32'(wr_ready), 32'd0);
        chk("post_reset_valid", {30'd0, slot1_valid, slot0_valid}, 32'd0);
`ifdef MAT_STORE_BOUNDS_CHECK_EN
        read(1, 0, 0);
        drain();
`endif

        // random loads and reads
        for (int it = 0; it < 8; it++) begin
            load($urandom_range(1), $urandom_range(MD, 1), $urandom_range(MD, 1), 30, -1, 1'b0);
            for (int j = 0; j < 10; j++) begin
                s = $urandom_range(1);
                if (!m_valid[s]) s = 1 - s;
                if (!m_valid[s]) continue;
`ifdef MAT_STORE_BOUNDS_CHECK_EN
                r = $urandom_range(7);
                c = $urandom_range(7);
`else
                r = $urandom_range(m_rows[s] - 1);
                c = $urandom_range(m_cols[s] - 1);
`endif
                read(s, r, c);
            end
            drain();
        end

        drain();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_store.md
Name: mat_store

Overview:
- Two-slot matrix storage that sits directly upstream of the matrix multiplier.
- Accepts row-major element streams from the input/parse stage and holds dimensions and valid flags per slot.
- Serves the multiplier's random-access read port (rd_en/slot/row/col -> rd_elem/rd_elem_valid) with fixed 1-cycle latency.
- Per-slot valid flags and dimensions drive the multiplier's slot_*_valid and m/n inputs.

Parameters:
- DIM_WIDTH, 3, width of row/col indices and dimensions.
- DATA_WIDTH, 8, element width.
- MAX_DIM, 5, largest legal row/column count (1..MAX_DIM); each slot holds MAX_DIM*MAX_DIM elements, address = row*MAX_DIM+col.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_begin  in  1  one-cycle pulse: start loading a slot
- wr_slot  in  1  target slot, sampled on wr_begin
- wr_rows  in  DIM_WIDTH  row count, sampled on wr_begin
- wr_cols  in  DIM_WIDTH  column count, sampled on wr_begin
- wr_valid  in  1  element present on wr_elem
- wr_elem  in  DATA_WIDTH  element, row-major order
- wr_abort  in  1  cancel load in progress
- wr_ready  out  1  high while accepting elements
- wr_done  out  1  one-cycle pulse: slot committed
- wr_error  out  1  one-cycle pulse: illegal dimensions
- rd_en  in  1  read request
- rd_slot_idx  in  1  read slot
- rd_row_idx  in  DIM_WIDTH  read row
- rd_col_idx  in  DIM_WIDTH  read column
- rd_elem  out  DATA_WIDTH  read data
- rd_elem_valid  out  1  read data valid, one cycle
- rd_oob  out  1  out-of-range flag (macro-dependent)
- slot0_valid, slot1_valid  out  1 each  slot holds a committed matrix
- slot0_rows, slot0_cols, slot1_rows, slot1_cols  out  DIM_WIDTH each  committed dimensions

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, write FSM in W_IDLE. Array contents are not reset.
- Write FSM states: W_IDLE, W_FILL, W_COMMIT.
- W_IDLE:
  - wr_begin with 1<=rows<=MAX_DIM and 1<=cols<=MAX_DIM: latch slot/rows/cols, clear row/col counters, clear that slot's valid flag in the same edge, go to W_FILL.
  - wr_begin with illegal dimensions: wr_error=1 next cycle. No state change; slot valid flag and contents untouched.
  - wr_valid ignored.
- W_FILL:
  - wr_ready=1. An element is accepted when wr_valid&&wr_ready and written to [row][col].
  - col increments; at col==cols-1 it wraps to 0 and row increments.
  - Accepting element (rows-1, cols-1) moves the FSM to W_COMMIT; wr_ready drops the cycle after that accept.
  - wr_begin is ignored in W_FILL.
  - wr_abort has priority over a same-cycle wr_valid: the element is discarded, FSM returns to W_IDLE, slot stays invalid.
- W_COMMIT (one cycle):
  - Publish slotN_rows/cols and set slotN_valid; wr_done=1 for one cycle; return to W_IDLE.
  - slotN_valid and wr_done are visible in the same cycle.
- Read port (independent of the write FSM):
  - rd_en at cycle t gives rd_elem and rd_elem_valid=1 at t+1, for exactly one cycle.
  - rd_elem holds its last value when not valid.
  - Back-to-back reads: one result per cycle.
  - A read and a write to the same address in the same cycle returns the old data.
  - Reading a slot while it is loading returns whatever is stored. The slot is invalid, so the consumer must not start.
- Reset mid-load: FSM returns to W_IDLE and all slot valid flags clear.

Optional Feature:
- Macro MAT_STORE_BOUNDS_CHECK_EN.
- Defined: a read with row>=slot rows, col>=slot cols, or the slot invalid returns rd_elem=0 with rd_oob=1 alongside rd_elem_valid. rd_oob is 0 for legal reads.
- Undefined: no check, rd_oob tied 0, out-of-range rd_elem is unspecified. The bench checks only in-range reads.

Test Plan:
- Load slot0 as 2x3 with 1,2,3,4,5,6 (wr_valid continuous) -> wr_done one cycle after the 6th accept; slot0_valid=1, slot0_rows=2, slot0_cols=3; reading (1,2) returns 6 exactly one cycle after rd_en.
- Load slot1 as 3x2 with gaps in wr_valid, then issue 6 back-to-back reads -> 6 consecutive valid cycles in row-major order; slot0 unaffected.
- wr_begin rows=0 cols=3, then rows=6 (MAX_DIM=5) -> two wr_error pulses; a previously valid slot stays valid; wr_ready never rises.
- Reload valid slot0 as 2x2, abort after 2 elements -> slot0_valid drops on wr_begin and stays 0; no wr_done; FSM accepts a new wr_begin next cycle.
- Assert rst_n low during W_FILL -> all outputs 0 immediately; after release, wr_ready=0 and both slots invalid.
- With MAT_STORE_BOUNDS_CHECK_EN defined, read row 2 of a 2x3 slot0 -> rd_elem=0, rd_oob=1, rd_elem_valid=1.
